// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 slave-side bundle for wb_bram_burst; names are from the slave's view
// (_i driven by the master, _o driven by the memory).
interface wb_bram_burst_if #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) ();
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    we_i;
  logic [SELECT_WIDTH-1:0] sel_i;
  logic                    stb_i;
  logic                    cyc_i;
  logic [2:0]              cti_i;
  logic [1:0]              bte_i;
  logic                    ack_o;
  logic                    err_o;

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 single-port RAM slave with registered-feedback (CTI/BTE) bursts,
// byte lane writes and a bus error for word indices beyond MEM_DEPTH.
module wb_bram_burst #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH    = 1024
) (
  input logic            clk,
  input logic            rst_n,
  wb_bram_burst_if.slave wb
);
  localparam int LSB_W  = $clog2(SELECT_WIDTH);
  localparam int WIDX_W = ADDR_WIDTH - LSB_W;
  localparam int MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WIDX_W:0] DEPTH_C = (WIDX_W + 1)'(MEM_DEPTH);
  localparam logic [2:0] CTI_INC = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACK1  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  state_e                state_q;
  logic                  ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [WIDX_W-1:0]     pred_q;

  logic [WIDX_W-1:0] widx_s;
  logic [WIDX_W-1:0] nxt_s;
  logic [MIDX_W-1:0] widx_m_s;
  logic [MIDX_W-1:0] nxt_m_s;
  logic              req_s;
  logic              hit_s;
  logic              ack_s;
  logic              xfer_s;
  logic              widx_ok_s;
  logic              nxt_ok_s;
  logic              cont_s;

  // Wrap-N keeps the upper index bits and counts the low log2(N) bits modulo N;
  // linear is the degenerate case where every bit takes part in the increment.
  function automatic logic [WIDX_W-1:0] next_index(input logic [WIDX_W-1:0] w,
                                                   input logic [1:0]        bte);
    logic [WIDX_W-1:0] mask;
    case (bte)
      2'b01:   mask = WIDX_W'(3);
      2'b10:   mask = WIDX_W'(7);
      2'b11:   mask = WIDX_W'(15);
      default: mask = '1;
    endcase
    return (w & ~mask) | ((w + WIDX_W'(1)) & mask);
  endfunction

  assign widx_s    = wb.adr_i[ADDR_WIDTH-1:LSB_W];
  assign nxt_s     = next_index(widx_s, wb.bte_i);
  assign widx_ok_s = {1'b0, widx_s} < DEPTH_C;
  assign nxt_ok_s  = {1'b0, nxt_s} < DEPTH_C;
  assign widx_m_s  = widx_s[MIDX_W-1:0];
  assign nxt_m_s   = nxt_s[MIDX_W-1:0];
  assign req_s     = wb.cyc_i & wb.stb_i;
  // While streaming, ack is only valid if the master really asks for the prefetched word.
  assign hit_s     = (state_q != S_BURST) | (widx_s == pred_q);
  assign ack_s     = ack_q & hit_s;
  assign xfer_s    = req_s & ack_s;
  assign cont_s    = (wb.cti_i == CTI_INC) & nxt_ok_s;

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_s;
  assign wb.err_o = err_q;

  generate
    if (LSB_W > 0) begin : g_lsb
      logic unused_adr_lsb;
      assign unused_adr_lsb = ^wb.adr_i[LSB_W-1:0];
    end
  endgenerate

  // Bus FSM: first-beat read, burst prefetch and registered ack/err/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      pred_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          // A cycle with err_q high is the error's terminating beat, not a new request.
          if (req_s && !err_q) begin
            if (widx_ok_s) begin
              dat_q   <= mem_q[widx_m_s];
              ack_q   <= 1'b1;
              state_q <= S_ACK1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ACK1, S_BURST: begin
          err_q <= 1'b0;
          if (xfer_s && cont_s) begin
            dat_q   <= mem_q[nxt_m_s];
            pred_q  <= nxt_s;
            ack_q   <= 1'b1;
            state_q <= S_BURST;
          end else begin
            ack_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Byte-lane write on a completed beat; ack_q clears asynchronously so reset blocks it.
  always_ff @(posedge clk) begin
    if (xfer_s && wb.we_i && widx_ok_s) begin
      for (int b = 0; b < SELECT_WIDTH; b++) begin
        if (wb.sel_i[b]) begin
          mem_q[widx_m_s][8*b +: 8] <= wb.dat_i[8*b +: 8];
        end
      end
    end
  end
endmodule
